iob_native_mem_responder: RTL and testbench

Native-interface memory responder: the slave end of the back-end port driven by the cache (`mem_valid`/`mem_addr`/`mem_wdata`/`mem_wstrb` → `mem_rdata`/`mem_ready`). It is backed by a byte-enabled word RAM. Access latency is programmable, with a shorter latency for sequential reads, so the cache's line-replacement and write-through paths are exercised with realistic timing. It also keeps read/write counters and a sticky protocol-error flag for the bench, and serves as the behavioural main memory behind the cache in simulation and FPGA tests.

---
 rtl/iob_native_mem_responder_pkg.sv | 19 +
 rtl/iob_native_mem_responder_ram.sv | 50 +++++
 rtl/iob_native_mem_responder.sv | 164 ++++++++++++++++
 tb/tb_iob_native_mem_responder.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/iob_native_mem_responder_pkg.sv
// Shared types and constants for the native-port memory responder.
// Holds the FSM state encoding and the default native-port field widths.
package iob_native_mem_responder_pkg;

    localparam int NATIVE_ADDR_W = 32;
    localparam int NATIVE_DATA_W = 32;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    // Width of the wait counter, which holds at most FIRST_LAT-2.
    function automatic int lat_cnt_w(input int first_lat);
        return (first_lat < 3) ? 1 : $clog2(first_lat);
    endfunction

endpackage

// File: rtl/iob_native_mem_responder_ram.sv
// Single-port byte-enabled word RAM with a registered read port.
// The read register updates only on reads, so it holds its value across writes.
module iob_native_mem_responder_ram #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 12,
    localparam int NBYTES = DATA_W / 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              en,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [NBYTES-1:0] wstrb,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem_r [0:(2**ADDR_W)-1];
    logic [DATA_W-1:0] merged_s;
    logic              is_rd_s;

    // Merge strobed write bytes into the addressed word.
    always_comb begin
        merged_s = mem_r[addr];
        is_rd_s  = (wstrb == {NBYTES{1'b0}});
        for (int b = 0; b < NBYTES; b++) begin
            if (wstrb[b]) begin
                merged_s[b*8 +: 8] = wdata[b*8 +: 8];
            end else begin
                merged_s[b*8 +: 8] = mem_r[addr][b*8 +: 8];
            end
        end
    end

    // Array write; contents are deliberately not cleared by reset.
    always_ff @(posedge clk) begin
        if (reset && en && !is_rd_s) begin
            mem_r[addr] <= merged_s;
        end
    end

    // Registered read port.
    always_ff @(posedge clk) begin
        if (!reset) begin
            rdata <= {DATA_W{1'b0}};
        end else if (en && is_rd_s) begin
            rdata <= mem_r[addr];
        end
    end

endmodule

// File: rtl/iob_native_mem_responder.sv
// Native-interface memory responder: latency-programmable slave backed by a word RAM,
// with a sequential-read fast path, access counters and a sticky protocol-error flag.
module iob_native_mem_responder
    import iob_native_mem_responder_pkg::*;
#(
    parameter int BE_ADDR_W  = NATIVE_ADDR_W,
    parameter int BE_DATA_W  = NATIVE_DATA_W,
    parameter int MEM_ADDR_W = 12,
    parameter int FIRST_LAT  = 4,
    parameter int SEQ_LAT    = 1,
    localparam int BE_NBYTES = BE_DATA_W / 8,
    localparam int BE_BYTE_W = $clog2(BE_NBYTES)
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 mem_valid,
    input  logic [BE_ADDR_W-1:0] mem_addr,
    input  logic [BE_DATA_W-1:0] mem_wdata,
    input  logic [BE_NBYTES-1:0] mem_wstrb,
    output logic [BE_DATA_W-1:0] mem_rdata,
    output logic                 mem_ready,
    output logic [31:0]          rd_cnt,
    output logic [31:0]          wr_cnt,
    output logic                 proto_err
);

    localparam int CNT_W = lat_cnt_w(FIRST_LAT);
    localparam logic [CNT_W-1:0] FIRST_CNT = (FIRST_LAT >= 2) ? CNT_W'(FIRST_LAT - 2) : {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] SEQ_CNT   = (SEQ_LAT >= 2) ? CNT_W'(SEQ_LAT - 2) : {CNT_W{1'b0}};

    state_t                 state_r;
    logic [CNT_W-1:0]       cnt_r;
    logic [BE_ADDR_W-1:0]   addr_r;
    logic [BE_DATA_W-1:0]   wdata_r;
    logic [BE_NBYTES-1:0]   wstrb_r;
    logic [MEM_ADDR_W-1:0]  last_idx_r;
    logic                   last_rd_r;
    logic                   last_vld_r;

    logic [MEM_ADDR_W-1:0]  req_idx_s;
    logic [MEM_ADDR_W-1:0]  next_idx_s;
    logic                   req_rd_s;
    logic                   seq_hit_s;
    logic                   lat_one_s;
    logic                   access_s;
    logic                   proto_viol_s;
    logic [MEM_ADDR_W-1:0]  acc_idx_s;
    logic [BE_DATA_W-1:0]   acc_wdata_s;
    logic [BE_NBYTES-1:0]   acc_wstrb_s;
    logic                   acc_rd_s;

    // Request decode, latency selection and choice of live vs captured access fields.
    always_comb begin
        req_idx_s  = mem_addr[BE_BYTE_W +: MEM_ADDR_W];
        next_idx_s = last_idx_r + {{(MEM_ADDR_W-1){1'b0}}, 1'b1};
        req_rd_s   = (mem_wstrb == {BE_NBYTES{1'b0}});
        seq_hit_s  = req_rd_s && last_vld_r && last_rd_r && (req_idx_s == next_idx_s);
        if (seq_hit_s) begin
            lat_one_s = (SEQ_LAT == 1);
        end else begin
            lat_one_s = (FIRST_LAT == 1);
        end
        access_s     = 1'b0;
        proto_viol_s = 1'b0;
        acc_idx_s    = addr_r[BE_BYTE_W +: MEM_ADDR_W];
        acc_wdata_s  = wdata_r;
        acc_wstrb_s  = wstrb_r;
        case (state_r)
            ST_IDLE: begin
                // A single-cycle access bypasses the capture registers.
                access_s    = mem_valid && lat_one_s;
                acc_idx_s   = req_idx_s;
                acc_wdata_s = mem_wdata;
                acc_wstrb_s = mem_wstrb;
            end
            ST_WAIT: begin
                access_s     = (cnt_r == {CNT_W{1'b0}});
                proto_viol_s = !mem_valid || (mem_addr != addr_r) || (mem_wstrb != wstrb_r);
            end
            ST_RESP: begin
                access_s = 1'b0;
            end
            default: begin
                access_s = 1'b0;
            end
        endcase
        acc_rd_s = (acc_wstrb_s == {BE_NBYTES{1'b0}});
    end

    // FSM, latency counter, sequential tracker and statistics.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_r    <= ST_IDLE;
            cnt_r      <= {CNT_W{1'b0}};
            addr_r     <= {BE_ADDR_W{1'b0}};
            wdata_r    <= {BE_DATA_W{1'b0}};
            wstrb_r    <= {BE_NBYTES{1'b0}};
            last_idx_r <= {MEM_ADDR_W{1'b0}};
            last_rd_r  <= 1'b0;
            last_vld_r <= 1'b0;
            mem_ready  <= 1'b0;
            rd_cnt     <= 32'd0;
            wr_cnt     <= 32'd0;
            proto_err  <= 1'b0;
        end else begin
            mem_ready <= access_s;
            if (proto_viol_s) begin
                proto_err <= 1'b1;
            end
            if (access_s) begin
                if (acc_rd_s) begin
                    rd_cnt <= rd_cnt + 32'd1;
                end else begin
                    wr_cnt <= wr_cnt + 32'd1;
                end
                last_idx_r <= acc_idx_s;
                last_rd_r  <= acc_rd_s;
                last_vld_r <= 1'b1;
            end
            case (state_r)
                ST_IDLE: begin
                    if (mem_valid) begin
                        addr_r  <= mem_addr;
                        wdata_r <= mem_wdata;
                        wstrb_r <= mem_wstrb;
                        if (lat_one_s) begin
                            state_r <= ST_RESP;
                        end else begin
                            state_r <= ST_WAIT;
                            cnt_r   <= seq_hit_s ? SEQ_CNT : FIRST_CNT;
                        end
                    end
                end
                ST_WAIT: begin
                    if (cnt_r == {CNT_W{1'b0}}) begin
                        state_r <= ST_RESP;
                    end else begin
                        cnt_r <= cnt_r - {{(CNT_W-1){1'b0}}, 1'b1};
                    end
                end
                ST_RESP: begin
                    state_r <= ST_IDLE;
                end
                default: begin
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

    iob_native_mem_responder_ram #(
        .DATA_W (BE_DATA_W),
        .ADDR_W (MEM_ADDR_W)
    ) u_ram (
        .clk   (clk),
        .reset (reset),
        .en    (access_s),
        .addr  (acc_idx_s),
        .wdata (acc_wdata_s),
        .wstrb (acc_wstrb_s),
        .rdata (mem_rdata)
    );

endmodule

// File: tb/tb_iob_native_mem_responder.sv
// Directed plus randomized bench for iob_native_mem_responder against a word-array
// reference model that derives latency, data and counters from the access rules.
module tb_iob_native_mem_responder;

    localparam int MAW = 4;
    localparam int NW  = 2 ** MAW;
    localparam int FL  = 4;
    localparam int SL  = 1;

    logic        clk = 1'b0;
    logic        reset;
    logic        mem_valid;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wstrb;
    logic [31:0] mem_rdata;
    logic        mem_ready;
    logic [31:0] rd_cnt;
    logic [31:0] wr_cnt;
    logic        proto_err;

    always #5 clk = ~clk;

    iob_native_mem_responder #(
        .BE_ADDR_W  (32),
        .BE_DATA_W  (32),
        .MEM_ADDR_W (MAW),
        .FIRST_LAT  (FL),
        .SEQ_LAT    (SL)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .mem_valid (mem_valid),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_wstrb (mem_wstrb),
        .mem_rdata (mem_rdata),
        .mem_ready (mem_ready),
        .rd_cnt    (rd_cnt),
        .wr_cnt    (wr_cnt),
        .proto_err (proto_err)
    );

    int n_cmp = 0;
    int n_bad = 0;

    // reference model state
    logic [31:0] m_mem [NW];
    logic [31:0] m_rd_cnt, m_wr_cnt, m_rdata;
    bit          m_perr, m_last_vld, m_last_rd;
    int          m_last_idx;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic int word_of(input logic [31:0] addr);
        return int'((addr >> 2) % NW);
    endfunction

    function automatic int model_lat(input logic [31:0] addr, input logic [3:0] strb);
        if (strb == 4'h0 && m_last_vld && m_last_rd && word_of(addr) == (m_last_idx + 1) % NW)
            return SL;
        return FL;
    endfunction

    task automatic model_reset();
        m_rd_cnt = 32'd0; m_wr_cnt = 32'd0; m_rdata = 32'd0;
        m_perr = 1'b0; m_last_vld = 1'b0; m_last_rd = 1'b0; m_last_idx = 0;
    endtask

    task automatic model_commit(input logic [31:0] addr, input logic [31:0] wdata, input logic [3:0] strb);
        int idx;
        idx = word_of(addr);
        if (strb == 4'h0) begin
            m_rdata = m_mem[idx];
            m_rd_cnt++;
        end else begin
            for (int b = 0; b < 4; b++)
                if (strb[b]) m_mem[idx][b*8 +: 8] = wdata[b*8 +: 8];
            m_wr_cnt++;
        end
        m_last_idx = idx; m_last_rd = (strb == 4'h0); m_last_vld = 1'b1;
    endtask

    // Issue one request; extra=1 when entered right after a ready with valid held high.
    task automatic xfer(input logic [31:0] addr, input logic [31:0] wdata, input logic [3:0] strb,
                        input bit keep, input int extra, input string tag);
        int lat, n;
        lat = model_lat(addr, strb) + extra;
        mem_valid = 1'b1; mem_addr = addr; mem_wdata = wdata; mem_wstrb = strb;
        n = 0;
        while (n < 20) begin
            @(posedge clk); #1;
            n++;
            if (mem_ready) break;
        end
        model_commit(addr, wdata, strb);
        chk({tag, " latency"}, 32'(n), 32'(lat));
        chk({tag, " rdata"}, mem_rdata, m_rdata);
        chk({tag, " rd_cnt"}, rd_cnt, m_rd_cnt);
        chk({tag, " wr_cnt"}, wr_cnt, m_wr_cnt);
        chk({tag, " proto_err"}, {31'd0, proto_err}, {31'd0, m_perr});
        if (!keep) begin
            mem_valid = 1'b0; mem_wstrb = 4'h0;
            @(posedge clk); #1;
            chk({tag, " single pulse"}, {31'd0, mem_ready}, 32'd0);
        end
    endtask

    initial begin
        logic [31:0] a, d;
        logic [3:0]  s;
        bit          keep, prev_keep;
        int          n, lat;

        reset = 1'b0; mem_valid = 1'b0; mem_addr = 32'd0; mem_wdata = 32'd0; mem_wstrb = 4'h0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        chk("reset ready", {31'd0, mem_ready}, 32'd0);
        chk("reset rdata", mem_rdata, 32'd0);
        chk("reset rd_cnt", rd_cnt, 32'd0);
        chk("reset wr_cnt", wr_cnt, 32'd0);
        chk("reset proto_err", {31'd0, proto_err}, 32'd0);
        reset = 1'b1;

        for (int i = 0; i < NW; i++) xfer(32'(i * 4), $urandom, 4'hF, 1'b0, 0, "fill");

        xfer(32'h10, 32'hDEADBEEF, 4'hF, 1'b0, 0, "dflt wr");
        xfer(32'h10, 32'h0, 4'h0, 1'b0, 0, "dflt rd");
        chk("dflt value", mem_rdata, 32'hDEADBEEF);

        xfer(32'h20, 32'h11223344, 4'hF, 1'b0, 0, "part pre");
        xfer(32'h20, 32'hAABBCCDD, 4'b0101, 1'b0, 0, "part wr");
        xfer(32'h20, 32'h0, 4'h0, 1'b0, 0, "part rd");
        chk("part value", mem_rdata, 32'h11BB33DD);

        xfer(32'h100, 32'h0, 4'h0, 1'b1, 0, "burst0");
        xfer(32'h104, 32'h0, 4'h0, 1'b1, 1, "burst1");
        xfer(32'h108, 32'h0, 4'h0, 1'b1, 1, "burst2");
        xfer(32'h10C, 32'h0, 4'h0, 1'b0, 1, "burst3");
        xfer(32'h200, 32'h0, 4'h0, 1'b0, 0, "jump rd");
        xfer(32'h204, 32'h5A5A5A5A, 4'hF, 1'b0, 0, "seqwr wr");
        xfer(32'h208, 32'h0, 4'h0, 1'b0, 0, "seqwr rd");

        xfer(32'h3C, 32'h0, 4'h0, 1'b0, 0, "wrap idx15");
        xfer(32'h00, 32'h0, 4'h0, 1'b0, 0, "wrap idx0");
        xfer(32'h40, 32'h0, 4'h0, 1'b0, 0, "alias 0x40");

        prev_keep = 1'b0;
        for (int i = 0; i < 60; i++) begin
            case ($urandom_range(0, 3))
                0: begin
                    a = 32'(((m_last_idx + 1) % NW) * 4) | ($urandom << 6) | 32'($urandom_range(0, 3));
                    s = 4'h0;
                end
                1: begin a = $urandom; s = 4'h0; end
                default: begin a = $urandom; s = 4'($urandom_range(0, 15)); end
            endcase
            d = $urandom;
            keep = 1'($urandom_range(0, 1));
            xfer(a, d, s, keep, prev_keep ? 1 : 0, "random");
            prev_keep = keep;
        end
        if (prev_keep) begin
            mem_valid = 1'b0; mem_wstrb = 4'h0;
            @(posedge clk); #1;
        end

        xfer(32'h34, 32'hCAFEF00D, 4'hF, 1'b0, 0, "perr pre");
        lat = model_lat(32'h30, 4'h0);
        mem_valid = 1'b1; mem_addr = 32'h30; mem_wstrb = 4'h0;
        @(posedge clk); #1;
        n = 1;
        mem_valid = 1'b0; mem_addr = $urandom;
        while (!mem_ready && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        model_commit(32'h30, 32'h0, 4'h0);
        m_perr = 1'b1;
        chk("perr latency", 32'(n), 32'(lat));
        chk("perr rdata", mem_rdata, m_rdata);
        chk("perr flag", {31'd0, proto_err}, 32'd1);
        @(posedge clk); #1;
        chk("perr single pulse", {31'd0, mem_ready}, 32'd0);
        xfer(32'h30, 32'h0, 4'h0, 1'b0, 0, "perr sticky");

        mem_valid = 1'b1; mem_addr = 32'h2C; mem_wdata = $urandom; mem_wstrb = 4'hF;
        @(posedge clk); #1;
        @(posedge clk); #1;
        reset = 1'b0; mem_valid = 1'b0; mem_wstrb = 4'h0;
        @(posedge clk); #1;
        model_reset();
        chk("abort ready", {31'd0, mem_ready}, 32'd0);
        chk("abort rdata", mem_rdata, 32'd0);
        chk("abort wr_cnt", wr_cnt, 32'd0);
        chk("abort proto_err", {31'd0, proto_err}, 32'd0);
        reset = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            chk("abort no pulse", {31'd0, mem_ready}, 32'd0);
        end
        xfer(32'h2C, 32'h0, 4'h0, 1'b0, 0, "abort readback");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
